// File: rtl/ram_param.sv
// ----------------------------------------------------------------------------
// ram_param : single-port word RAM with byte-lane write enables and a
//             registered read port.
//
// Build option : RAM_CLEAR_EN -- when defined, the RAM writes zero to every
//                word, one per cycle, after each reset release, and holds
//                busy high until that is done. When undefined there is no
//                clear sequence, busy is tied low and the contents stay
//                undefined until they are written.
//
// Parameters
//   DATA_W   word width in bits (multiple of 8)
//   ADDR_W   address width, depth = 2**ADDR_W words
//
// Ports
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset (the array is not reset)
//   ena       in   access enable
//   wena      in   1 = write, 0 = read (when ena = 1)
//   be        in   byte-lane write enables, bit i gates bits [8i+7:8i]
//   addr      in   word address
//   data_in   in   write data
//   data_out  out  registered read data, holds between reads
//   rd_valid  out  one-cycle pulse marking a new data_out
//   busy      out  high while the clear sequence runs; accesses ignored
// ----------------------------------------------------------------------------
module ram_param #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ena,
   input  logic                  wena,
   input  logic [DATA_W/8-1:0]   be,
   input  logic [ADDR_W-1:0]     addr,
   input  logic [DATA_W-1:0]     data_in,
   output logic [DATA_W-1:0]     data_out,
   output logic                  rd_valid,
   output logic                  busy
);

   localparam int LANES = DATA_W / 8;
   localparam int DEPTH = 1 << ADDR_W;

   // Write-port controls, shared between the clear sequence and user writes.
   logic                mem_we;
   logic [LANES-1:0]    mem_be;
   logic [ADDR_W-1:0]   mem_addr;
   logic [DATA_W-1:0]   mem_wdata;
   logic                rd_en;
   logic [DATA_W-1:0]   rd_word;

   logic [DATA_W-1:0]   data_out_q;
   logic                rd_valid_q;

`ifdef RAM_CLEAR_EN
   typedef enum logic {CLEAR, READY} state_t;

   state_t              state_q;
   logic [ADDR_W-1:0]   cnt_q;
   logic                busy_q;
   logic                clearing;

   // Clear sequencer: walks the counter over every word, then parks in READY.
   // busy is a registered copy of the state so it falls on the same edge the
   // last word is written.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= CLEAR;
         cnt_q   <= '0;
         busy_q  <= 1'b1;
      end else begin
         case (state_q)
            CLEAR: begin
               if (cnt_q == {ADDR_W{1'b1}}) begin
                  state_q <= READY;
                  busy_q  <= 1'b0;
                  cnt_q   <= '0;
               end else begin
                  cnt_q   <= cnt_q + 1'b1;
               end
            end
            READY: begin
               state_q <= READY;
            end
            default: begin
               state_q <= CLEAR;
               cnt_q   <= '0;
               busy_q  <= 1'b1;
            end
         endcase
      end
   end

   assign clearing  = (state_q == CLEAR);

   // While clearing, the user port is ignored entirely.
   assign mem_we    = clearing | (ena & wena);
   assign mem_be    = clearing ? {LANES{1'b1}} : be;
   assign mem_addr  = clearing ? cnt_q : addr;
   assign mem_wdata = clearing ? '0 : data_in;
   assign rd_en     = ~clearing & ena & ~wena;
   assign busy      = busy_q;
`else
   assign mem_we    = ena & wena;
   assign mem_be    = be;
   assign mem_addr  = addr;
   assign mem_wdata = data_in;
   assign rd_en     = ena & ~wena;
   assign busy      = 1'b0;
`endif

   // One 8-bit-wide array per byte lane so each lane has its own write enable.
   // The array has no reset: contents survive rst_n and only the clear
   // sequence (when built in) zeroes them.
   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         logic [7:0] lane_mem [DEPTH];

         always_ff @(posedge clk) begin
            if (mem_we && mem_be[gi]) begin
               lane_mem[mem_addr] <= mem_wdata[8*gi +: 8];
            end
         end

         assign rd_word[8*gi +: 8] = lane_mem[addr];
      end
   endgenerate

   // Registered read. A write committed on the previous edge is already in
   // the array, so a read that follows it directly sees the new data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out_q <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= rd_en;
         if (rd_en) begin
            data_out_q <= rd_word;
         end
      end
   end

   assign data_out = data_out_q;
   assign rd_valid = rd_valid_q;

endmodule
